// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch sequencer between a synchronous program ROM and a 9-bit
// datapath. It fetches one instruction word, plus a trailing immediate word
// for move-immediate instructions. It issues the instruction with a one-cycle
// `run` pulse and then holds until the datapath reports `Done` before
// advancing the program counter.
//
// Parameters
//   AW      ROM address width (program space is 2^AW words)
//   DW      instruction/data word width; opcode is [DW-1:DW-3]
//   MVI_OP  opcode whose instruction carries a trailing immediate word
//
// Ports
//   clk       in   clock, all state on the rising edge
//   rst       in   asynchronous active-low reset
//   start     in   level, sampled in IDLE; begins execution from pc
//   stop      in   level; finish the instruction in flight, then go idle
//   rom_addr  out  ROM address (combinational from state and pc)
//   rom_q     in   ROM read data, valid the cycle after rom_addr
//   run       out  one-cycle issue pulse to the datapath
//   DIN       out  instruction during run, then immediate/instruction
//   Done      in   datapath completion, sampled only in WAIT
//   pc        out  address of the next instruction to fetch
//   busy      out  high in every state except IDLE and HALT
//   halted    out  high in HALT
//
// Configuration
//   INSTR_FETCH_HALT_EN  when defined, an all-zero instruction word is a halt:
//                        it is not issued and the sequencer parks in HALT
//                        until reset. When undefined, all-zero is an ordinary
//                        instruction and `halted` is tied low.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int         AW     = 5,
    parameter int         DW     = 9,
    parameter logic [2:0] MVI_OP = 3'b001
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          run,
    output logic [DW-1:0] DIN,
    input  logic          Done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CAPT  = 3'd2,
        S_IADDR = 3'd3,
        S_ICAPT = 3'd4,
        S_ISSUE = 3'd5,
        S_WAIT  = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    state_t        state_q, state_d;

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          stop_q, stop_d;

    logic          run_q, run_d;
    logic [DW-1:0] din_q, din_d;
    logic          busy_q, busy_d;

    logic          rom_is_mvi;
    logic          ir_is_mvi;
    logic          halt_word;
    logic          wait_done;
    logic          active;

    // Opcode decode: the live ROM word steers the CAPT branch, the captured
    // instruction steers DIN selection and the pc step in WAIT.
    assign rom_is_mvi = (rom_q[DW-1:DW-3] == MVI_OP);
    assign ir_is_mvi  = (ir_q[DW-1:DW-3] == MVI_OP);
    assign wait_done  = (state_q == S_WAIT) && Done;
    assign active     = (state_q != S_IDLE) && (state_q != S_HALT);

`ifdef INSTR_FETCH_HALT_EN
    assign halt_word = (rom_q == '0);

    logic halted_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_d == S_HALT);
        end
    end

    assign halted = halted_q;
`else
    assign halt_word = 1'b0;
    assign halted    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register and all registered datapath/output state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            stop_q  <= 1'b0;
            run_q   <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            stop_q  <= stop_d;
            run_q   <= run_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                if (rom_is_mvi) begin
                    state_d = S_IADDR;
                end else if (halt_word) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_IADDR: begin
                state_d = S_ICAPT;
            end
            S_ICAPT: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A stop arriving in the same cycle as Done still counts.
                if (Done) begin
                    state_d = (stop_q || stop) ? S_IDLE : S_ADDR;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output and datapath next-value logic
    // -------------------------------------------------------------------------

    // The immediate lives one word past the instruction; address arithmetic
    // wraps naturally at AW bits, so an mvi in the last slot reads word 0.
    always_comb begin
        rom_addr = pc_q;
        if (state_q == S_IADDR) begin
            rom_addr = pc_q + AW'(1);
        end
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        imm_d  = imm_q;
        stop_d = stop_q;

        if (state_q == S_CAPT) begin
            ir_d = rom_q;
        end
        if (state_q == S_ICAPT) begin
            imm_d = rom_q;
        end

        if (wait_done) begin
            pc_d   = pc_q + (ir_is_mvi ? AW'(2) : AW'(1));
            stop_d = 1'b0;
        end else if (stop && (active || (state_q == S_IDLE && start))) begin
            // Remember the stop request until the current instruction retires.
            stop_d = 1'b1;
        end
    end

    // Registered outputs are computed from the upcoming state so they line
    // up with it: run is high exactly while in ISSUE, DIN switches to the
    // immediate on the first WAIT cycle.
    always_comb begin
        run_d  = (state_d == S_ISSUE);
        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
        din_d  = din_q;
        if (state_d == S_ISSUE) begin
            din_d = ir_d;
        end else if (state_d == S_WAIT) begin
            din_d = ir_is_mvi ? imm_q : ir_q;
        end
    end

    assign run  = run_q;
    assign DIN  = din_q;
    assign pc   = pc_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int         AW  = 5;
    localparam int         DW  = 9;
    localparam int         NW  = 32;
    localparam logic [2:0] MVI = 3'b001;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          run;
    logic [DW-1:0] DIN;
    logic          Done = 1'b0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    logic [DW-1:0] rom [NW];

    int n_tests = 0;
    int n_fail  = 0;
    int m_pc    = 0;

    instr_fetch #(.AW(AW), .DW(DW), .MVI_OP(MVI)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .run      (run),
        .DIN      (DIN),
        .Done     (Done),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: address registered, data valid next cycle.
    always @(posedge clk) rom_q <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom();
        logic [DW-1:0] w;
        for (int i = 0; i < NW; i++) begin
            w = DW'($urandom);
            if ($urandom_range(0, 2) == 0) w[DW-1:DW-3] = MVI;
            if (w == '0) w = 9'h001;
            rom[i] = w;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; Done = 1'b0;
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_run",      32'(run),      0);
        chk("rst_din",      32'(DIN),      0);
        chk("rst_pc",       32'(pc),       0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_halted",   32'(halted),   0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_pc = 0;
    endtask

    // Called at the negedge where start or Done has just been raised.
    // Follows one instruction from fetch to the cycle its Done is raised.
    task automatic issue_one(input int done_dly, input bit stop_pulse);
        logic [DW-1:0] iw, imm;
        bit            is_mvi;
        int            k;
        iw     = rom[m_pc];
        imm    = rom[(m_pc + 1) % NW];
        is_mvi = (iw[DW-1:DW-3] == MVI);

        @(negedge clk);
        k = 1;
        start = 1'b0; stop = 1'b0;
        Done  = 1'($urandom_range(0, 1));
        chk("pc_fetch",   32'(pc),       32'(m_pc));
        chk("addr_fetch", 32'(rom_addr), 32'(m_pc));
        chk("busy_fetch", 32'(busy),     1);
        while (!run && k < 12) begin
            @(negedge clk);
            k++;
            Done = 1'($urandom_range(0, 1));
            if (is_mvi && k == 3) chk("addr_imm", 32'(rom_addr), 32'((m_pc + 1) % NW));
        end
        chk("run_latency", 32'(k),   is_mvi ? 32'd5 : 32'd3);
        chk("din_issue",   32'(DIN), 32'(iw));

        for (int d = 0; d <= done_dly; d++) begin
            @(negedge clk);
            stop = (stop_pulse && d == 0);
            Done = 1'b0;
            if (d == 0) chk("run_pulse_len", 32'(run), 0);
            chk("din_wait", 32'(DIN), is_mvi ? 32'(imm) : 32'(iw));
        end
        Done = 1'b1;
        m_pc = (m_pc + (is_mvi ? 2 : 1)) % NW;
    endtask

    task automatic finish_last(input bit expect_idle);
        @(negedge clk);
        Done = 1'b0; stop = 1'b0;
        chk("pc_after",   32'(pc),   32'(m_pc));
        chk("busy_after", 32'(busy), expect_idle ? 32'd0 : 32'd1);
    endtask

    // Idle period with Done toggling randomly: no issue, no pc change.
    task automatic idle_quiet(input int n);
        int runs;
        runs = 0;
        repeat (n) begin
            @(negedge clk);
            Done = 1'($urandom_range(0, 1));
            if (run) runs++;
        end
        Done = 1'b0;
        chk("quiet_runs", 32'(runs), 0);
        chk("quiet_pc",   32'(pc),   32'(m_pc));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;

        // Directed mv / mvi pair, then a random program, then stop handling.
        fill_rom();
        rom[0] = 9'h00A;
        rom[1] = 9'h058;
        rom[2] = 9'h05A;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        issue_one(0, 1'b0);
        issue_one(1, 1'b0);
        for (int i = 0; i < 40; i++) issue_one($urandom_range(0, 3), 1'b0);
        issue_one(4, 1'b1);
        finish_last(1'b1);
        idle_quiet(10);

        // start and stop together in IDLE: one instruction, then idle again.
        start = 1'b1; stop = 1'b1;
        issue_one($urandom_range(0, 2), 1'b0);
        finish_last(1'b1);
        idle_quiet(5);

        // mvi in the last slot takes its immediate from word 0.
        rom[0] = 9'h1FF;
        for (int i = 1; i < NW - 1; i++) rom[i] = 9'h00A;
        rom[NW-1] = 9'h058;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        repeat (NW) issue_one(0, 1'b0);
        finish_last(1'b0);

        // Reset while an mvi is waiting for Done.
        rom[0] = 9'h00A;
        rom[1] = 9'h058;
        rom[2] = 9'h05A;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        issue_one(0, 1'b0);
        @(negedge clk);
        Done = 1'b0;
        k = 1;
        while (!run && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_latency", 32'(k), 5);
        repeat (2) @(negedge clk);
        chk("rstmid_din_imm", 32'(DIN), 32'h05A);
        chk("rstmid_pc_pre",  32'(pc),  1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_run",  32'(run),  0);
        chk("rstmid_din",  32'(DIN),  0);
        chk("rstmid_pc",   32'(pc),   0);
        chk("rstmid_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        m_pc = 0;
        idle_quiet(20);

        // All-zero word after two mv instructions.
        rom[0] = 9'h00A;
        rom[1] = 9'h111;
        rom[2] = 9'h000;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        issue_one(0, 1'b0);
        issue_one(0, 1'b0);
`ifdef INSTR_FETCH_HALT_EN
        begin
            int runs;
            runs = 0;
            @(negedge clk);
            Done = 1'b0;
            chk("halt_pc_pre", 32'(pc), 2);
            k = 1;
            while (!halted && k < 10) begin
                @(negedge clk);
                k++;
                if (run) runs++;
            end
            chk("halt_flag", 32'(halted), 1);
            chk("halt_runs", 32'(runs),   0);
            chk("halt_busy", 32'(busy),   0);
            start = 1'b1;
            idle_quiet(5);
            start = 1'b0;
            chk("halt_stays", 32'(halted), 1);
        end
`else
        issue_one(0, 1'b0);
        finish_last(1'b0);
        chk("nohalt_flag", 32'(halted), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
